serial_ctl_gen2: RTL

Parametrised successor to the serial shift-out controller. Shifts out a DATA_W-bit word on SS/SCLK/MOSI under Start. Adds configurable SCLK divider, CPOL/CPHA mode, bit order, CS setup/hold, and full-duplex MISO capture. Sits between the counter/control logic and the external serial DAC/shift-register chain.

---
 rtl/serial_ctl_gen2.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_ctl_gen2.sv
// serial_ctl_gen2: parametrised serial shift-out controller with configurable
// SCLK divider, CPOL/CPHA mode, bit order, CS setup/hold and full-duplex MISO
// capture. All outputs come straight from registers.
module serial_ctl_gen2 #(
    parameter int DATA_W      = 32,
    parameter int HALF_PERIOD = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int CS_SETUP    = 1,
    parameter int CS_HOLD     = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Data,
    input  logic              MISO,
    output logic              SS,
    output logic              SCLK,
    output logic              MOSI,
    output logic              Busy,
    output logic              DoneFlag,
    output logic [DATA_W-1:0] RxData,
    output logic [2:0]        CurrentStateOut
);

    localparam int TMR_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int HPC_W  = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic             IDLE_LVL   = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(HALF_PERIOD - 1);
    localparam logic [HPC_W-1:0] SETUP_LAST = HPC_W'(CS_SETUP - 1);
    localparam logic [HPC_W-1:0] HOLD_LAST  = HPC_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LEAD  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Bit that goes on the wire next, given the configured bit order.
    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        if (LSB_FIRST != 0) begin
            first_bit = v[0];
        end else begin
            first_bit = v[DATA_W-1];
        end
    endfunction

    // Drop the bit just transmitted so the next one sits at the output end.
    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v);
        if (LSB_FIRST != 0) begin
            shift_tx = {1'b0, v[DATA_W-1:1]};
        end else begin
            shift_tx = {v[DATA_W-2:0], 1'b0};
        end
    endfunction

    // Insert a received bit so the word assembles in transmit order.
    function automatic logic [DATA_W-1:0] rx_in(input logic [DATA_W-1:0] v, input logic b);
        if (LSB_FIRST != 0) begin
            rx_in = {b, v[DATA_W-1:1]};
        end else begin
            rx_in = {v[DATA_W-2:0], b};
        end
    endfunction

    state_t            state_r, state_s;
    logic [TMR_W-1:0]  tmr_r, tmr_s;
    logic [HPC_W-1:0]  hpc_r, hpc_s;
    logic [BIT_W-1:0]  bit_r, bit_s;
    logic [DATA_W-1:0] tx_r, tx_s;
    logic [DATA_W-1:0] rx_r, rx_s;
    logic [DATA_W-1:0] rxd_r, rxd_s;
    logic              ss_r, ss_s;
    logic              sclk_r, sclk_s;
    logic              mosi_r, mosi_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              start_prev_r;
    logic              start_rise_s;
    logic              tmr_done_s;
    logic              enter_lead_s;

    assign start_rise_s = Start & ~start_prev_r;
    assign tmr_done_s   = (tmr_r == TMR_LAST);

    // Next-state and next-output computation for the whole transfer sequence.
    always_comb begin
        state_s      = state_r;
        tmr_s        = tmr_r;
        hpc_s        = hpc_r;
        bit_s        = bit_r;
        tx_s         = tx_r;
        rx_s         = rx_r;
        rxd_s        = rxd_r;
        ss_s         = ss_r;
        sclk_s       = sclk_r;
        mosi_s       = mosi_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        enter_lead_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                tmr_s = {TMR_W{1'b0}};
                if (start_rise_s) begin
                    state_s = ST_SETUP;
                    hpc_s   = {HPC_W{1'b0}};
                    bit_s   = {BIT_W{1'b0}};
                    rx_s    = {DATA_W{1'b0}};
                    ss_s    = 1'b0;
                    busy_s  = 1'b1;
                    sclk_s  = IDLE_LVL;
                    if (CPHA == 0) begin
                        // First bit must be valid before the leading (sampling) edge.
                        mosi_s = first_bit(Data);
                        tx_s   = shift_tx(Data);
                    end else begin
                        mosi_s = 1'b0;
                        tx_s   = Data;
                    end
                end else begin
                    ss_s   = 1'b1;
                    busy_s = 1'b0;
                    sclk_s = IDLE_LVL;
                    mosi_s = 1'b0;
                end
            end
            ST_SETUP: begin
                tmr_s = tmr_done_s ? {TMR_W{1'b0}} : tmr_r + 1'b1;
                if (tmr_done_s) begin
                    if (hpc_r == SETUP_LAST) begin
                        state_s      = ST_LEAD;
                        hpc_s        = {HPC_W{1'b0}};
                        enter_lead_s = 1'b1;
                    end else begin
                        hpc_s = hpc_r + 1'b1;
                    end
                end else begin
                    hpc_s = hpc_r;
                end
            end
            ST_LEAD: begin
                tmr_s = tmr_done_s ? {TMR_W{1'b0}} : tmr_r + 1'b1;
                if (tmr_done_s) begin
                    state_s = ST_TRAIL;
                    sclk_s  = IDLE_LVL;
                    if (CPHA == 0) begin
                        // Shift the next bit on the trailing edge; keep the last bit through HOLD.
                        if (bit_r != BIT_LAST) begin
                            mosi_s = first_bit(tx_r);
                            tx_s   = shift_tx(tx_r);
                        end else begin
                            mosi_s = mosi_r;
                        end
                    end else begin
                        rx_s = rx_in(rx_r, MISO);
                    end
                end else begin
                    sclk_s = sclk_r;
                end
            end
            ST_TRAIL: begin
                tmr_s = tmr_done_s ? {TMR_W{1'b0}} : tmr_r + 1'b1;
                if (tmr_done_s) begin
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_HOLD;
                        hpc_s   = {HPC_W{1'b0}};
                    end else begin
                        state_s      = ST_LEAD;
                        bit_s        = bit_r + 1'b1;
                        enter_lead_s = 1'b1;
                    end
                end else begin
                    bit_s = bit_r;
                end
            end
            ST_HOLD: begin
                tmr_s = tmr_done_s ? {TMR_W{1'b0}} : tmr_r + 1'b1;
                if (tmr_done_s) begin
                    if (hpc_r == HOLD_LAST) begin
                        state_s = ST_DONE;
                        ss_s    = 1'b1;
                        done_s  = 1'b1;
                        rxd_s   = rx_r;
                        mosi_s  = 1'b0;
                    end else begin
                        hpc_s = hpc_r + 1'b1;
                    end
                end else begin
                    hpc_s = hpc_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                tmr_s   = {TMR_W{1'b0}};
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                tmr_s   = {TMR_W{1'b0}};
                ss_s    = 1'b1;
                sclk_s  = IDLE_LVL;
                mosi_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        // Leading SCLK edge: shared by the SETUP->LEAD and TRAIL->LEAD paths.
        if (enter_lead_s) begin
            sclk_s = ~IDLE_LVL;
            if (CPHA == 0) begin
                rx_s = rx_in(rx_r, MISO);
            end else begin
                mosi_s = first_bit(tx_r);
                tx_s   = shift_tx(tx_r);
            end
        end else begin
        end
    end

    // State, datapath and output registers; Start edge detector primed high
    // so a Start already asserted at reset release is not seen as an edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            tmr_r        <= {TMR_W{1'b0}};
            hpc_r        <= {HPC_W{1'b0}};
            bit_r        <= {BIT_W{1'b0}};
            tx_r         <= {DATA_W{1'b0}};
            rx_r         <= {DATA_W{1'b0}};
            rxd_r        <= {DATA_W{1'b0}};
            ss_r         <= 1'b1;
            sclk_r       <= IDLE_LVL;
            mosi_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            start_prev_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            tmr_r        <= tmr_s;
            hpc_r        <= hpc_s;
            bit_r        <= bit_s;
            tx_r         <= tx_s;
            rx_r         <= rx_s;
            rxd_r        <= rxd_s;
            ss_r         <= ss_s;
            sclk_r       <= sclk_s;
            mosi_r       <= mosi_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            start_prev_r <= Start;
        end
    end

    assign SS              = ss_r;
    assign SCLK            = sclk_r;
    assign MOSI            = mosi_r;
    assign Busy            = busy_r;
    assign DoneFlag        = done_r;
    assign RxData          = rxd_r;
    assign CurrentStateOut = state_r;

endmodule
